// File: rtl/pk_req_arbiter.sv
// Round-robin owner of the shared public-key generator: one request in flight, result routed back to its requester.
// Accept->response 3 cycles nominal, 2 on invalid key, 2+TIMEOUT on generator stall; req_ready only in IDLE.
module pk_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_seckey,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_pubkey,
    output logic                 rsp_err,
    output logic [1:0]           gen_mode,
    output logic [7:0]           gen_seckey,
    input  logic [7:0]           gen_pubkey,
    input  logic                 gen_pk_ready,
    input  logic                 gen_err
);
    localparam int              PW       = $clog2(N_REQ);
    localparam logic [3:0]      TMO      = 4'(TIMEOUT);
    localparam logic [PW-1:0]   LAST_RST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       last_grant;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       cand;
    logic                any_req;
    logic [3:0]          tmo_cnt;
    logic [3:0]          tmo_inc;
    logic [3:0]          tmo_cnt_nxt;
    logic                tmo_hit;
    logic [7:0]          key_arr [N_REQ];

    logic [N_REQ-1:0]    rsp_valid_nxt;
    logic [7:0]          rsp_pubkey_nxt;
    logic                rsp_err_nxt;
    logic [1:0]          gen_mode_nxt;
    logic [7:0]          gen_seckey_nxt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_key
        assign key_arr[g] = req_seckey[8*g +: 8];
    end

    // Scan from the farthest offset down so the closest requester after last_grant wins.
    always_comb begin
        pick    = last_grant;
        cand    = last_grant;
        any_req = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = PW'((int'(last_grant) + off) % N_REQ);
            if (req_valid[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    assign tmo_inc = (tmo_cnt == 4'hF) ? 4'hF : tmo_cnt + 4'd1;
    assign tmo_hit = (tmo_inc == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = gen_err ? RESP : WAIT;
            WAIT:    if (gen_pk_ready || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead so they line up with the state they belong to.
    always_comb begin
        req_ready      = '0;
        rsp_valid_nxt  = '0;
        rsp_pubkey_nxt = 8'h00;
        rsp_err_nxt    = 1'b0;
        gen_mode_nxt   = 2'b00;
        gen_seckey_nxt = 8'h00;
        tmo_cnt_nxt    = tmo_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[pick] = rst_n;
                    gen_mode_nxt    = 2'b01;
                    gen_seckey_nxt  = key_arr[pick];
                end
            end
            ISSUE: begin
                tmo_cnt_nxt = 4'd0;
                if (gen_err) begin
                    rsp_valid_nxt[idx] = 1'b1;
                    rsp_err_nxt        = 1'b1;
                end else begin
                    gen_mode_nxt   = 2'b01;
                    gen_seckey_nxt = gen_seckey;
                end
            end
            WAIT: begin
                tmo_cnt_nxt = tmo_inc;
                if (gen_pk_ready) begin
                    rsp_valid_nxt[idx] = 1'b1;
                    rsp_pubkey_nxt     = gen_pubkey;
                end else if (tmo_hit) begin
                    rsp_valid_nxt[idx] = 1'b1;
                    rsp_err_nxt        = 1'b1;
                end else begin
                    gen_mode_nxt   = 2'b01;
                    gen_seckey_nxt = gen_seckey;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= LAST_RST;
            idx        <= '0;
            tmo_cnt    <= 4'd0;
            rsp_valid  <= '0;
            rsp_pubkey <= 8'h00;
            rsp_err    <= 1'b0;
            gen_mode   <= 2'b00;
            gen_seckey <= 8'h00;
        end else begin
            tmo_cnt    <= tmo_cnt_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_pubkey <= rsp_pubkey_nxt;
            rsp_err    <= rsp_err_nxt;
            gen_mode   <= gen_mode_nxt;
            gen_seckey <= gen_seckey_nxt;
            if (state == IDLE && any_req) idx <= pick;
            if (state == RESP) last_grant <= idx;
        end
    end
endmodule

// File: tb/tb_pk_req_arbiter.sv
// Bench for pk_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_pk_req_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_seckey;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [7:0]       rsp_pubkey;
    logic             rsp_err;
    logic [1:0]       gen_mode;
    logic [7:0]       gen_seckey;
    logic [7:0]       gen_pubkey = 8'h00;
    logic             gen_pk_ready = 1'b0;
    logic             gen_err;
    logic             stub_dead = 1'b0;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    pk_req_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_seckey(req_seckey),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_pubkey(rsp_pubkey), .rsp_err(rsp_err),
        .gen_mode(gen_mode), .gen_seckey(gen_seckey), .gen_pubkey(gen_pubkey),
        .gen_pk_ready(gen_pk_ready), .gen_err(gen_err)
    );

    // Generator stand-in: Pk = (Sk + 225) mod 227, keys 0 and >=227 rejected.
    assign gen_err = (gen_seckey == 8'd0) || (gen_seckey >= 8'd227);
    always @(posedge clk) begin
        gen_pk_ready <= (gen_mode == 2'b01) && !gen_err && !stub_dead;
        gen_pubkey   <= 8'((int'(gen_seckey) + 225) % 227);
    end

    function automatic logic [7:0] pk_of(input int k);
        return 8'((k + 225) % 227);
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << i;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] m;
        for (int off = 1; off <= N; off++) begin
            m = v >> ((last + off) % N);
            if (m[0]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] rnd_key();
        if ($urandom_range(7, 0) == 0) return ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 227));
        return 8'($urandom_range(226, 1));
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] k);
        req_valid[i]          = v;
        req_seckey[8*i +: 8]  = k;
    endtask

    task automatic do_reset;
        req_valid  = '0;
        req_seckey = '0;
        stub_dead  = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns at the negedge of the accept cycle, or with got=0 when the budget runs out.
    task automatic wait_ready(input int max, output logic [N-1:0] got);
        got = '0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = req_ready;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = '1;
        req_seckey = 32'h0A0A0A0A;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_pubkey !== 8'h00 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b want=00/0", rsp_pubkey, rsp_err); end
        checks++; if (gen_mode !== 2'b00 || gen_seckey !== 8'h00) begin errors++; $display("FAIL reset_gen got=%b/%h want=00/00", gen_mode, gen_seckey); end
    endtask

    task automatic test_single;
        logic [N-1:0] got;
        do_reset;
        set_req(0, 1'b1, 8'd10);
        wait_ready(8, got);
        checks++; if (got !== 4'b0001) begin errors++; $display("FAIL single_accept got=%b want=0001", got); end
        checks++; if (gen_mode !== 2'b00) begin errors++; $display("FAIL single_mode_T got=%b want=00", gen_mode); end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) set_req(0, 1'b0, 8'd0);
            @(negedge clk);
            checks++; if (gen_mode !== ((k == 1 || k == 2) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_mode k=%0d got=%b", k, gen_mode); end
            checks++; if (rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_rsp_valid k=%0d got=%b", k, rsp_valid); end
            if (k == 2) begin
                checks++; if (gen_seckey !== 8'd10) begin errors++; $display("FAIL single_seckey got=%0d want=10", gen_seckey); end
            end
            if (k == 3) begin
                checks++; if (rsp_pubkey !== 8'd8 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_pubkey got=%0d/%b want=8/0", rsp_pubkey, rsp_err); end
            end
        end
    endtask

    task automatic test_round_robin;
        int keys [4] = '{1, 3, 10, 226};
        int order [5] = '{0, 1, 2, 3, 0};
        int n_acc = 0, n_rsp = 0, prev = -1, pend = -1;
        do_reset;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(keys[i]));
        for (int c = 0; c < 40 && n_acc < 5; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                n_rsp++;
                checks++;
                if (pend < 0 || rsp_valid !== oh(pend) || rsp_pubkey !== pk_of(keys[pend]) || c != prev + 3) begin
                    errors++; $display("FAIL rr_rsp c=%0d got=%b/%0d", c, rsp_valid, rsp_pubkey);
                end
            end
            if (req_ready != '0) begin
                checks++; if (req_ready !== oh(order[n_acc])) begin errors++; $display("FAIL rr_order n=%0d got=%b want=%b", n_acc, req_ready, oh(order[n_acc])); end
                if (prev >= 0) begin
                    checks++; if (c - prev != 4) begin errors++; $display("FAIL rr_spacing got=%0d want=4", c - prev); end
                end
                prev = c;
                pend = order[n_acc];
                n_acc++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n_acc != 5 || n_rsp != 4) begin errors++; $display("FAIL rr_count acc=%0d rsp=%0d want=5/4", n_acc, n_rsp); end
    endtask

    task automatic test_invalid_key;
        logic [N-1:0] got;
        logic [7:0] bad [2] = '{8'd0, 8'd227};
        do_reset;
        for (int b = 0; b < 2; b++) begin
            set_req(2, 1'b1, bad[b]);
            wait_ready(8, got);
            checks++; if (got !== 4'b0100) begin errors++; $display("FAIL inv_accept key=%0d got=%b", bad[b], got); end
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                if (k == 1) set_req(2, 1'b0, 8'd0);
                @(negedge clk);
                checks++; if (rsp_valid !== ((k == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL inv_rsp_valid key=%0d k=%0d got=%b", bad[b], k, rsp_valid); end
                if (k == 2) begin
                    checks++; if (rsp_err !== 1'b1 || rsp_pubkey !== 8'h00) begin errors++; $display("FAIL inv_rsp key=%0d got=%b/%h want=1/00", bad[b], rsp_err, rsp_pubkey); end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout;
        logic [N-1:0] got;
        do_reset;
        stub_dead = 1'b1;
        set_req(0, 1'b1, 8'd5);
        wait_ready(8, got);
        checks++; if (got !== 4'b0001) begin errors++; $display("FAIL tmo_accept got=%b", got); end
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) set_req(0, 1'b0, 8'd0);
            @(negedge clk);
            checks++; if (rsp_valid !== ((k == 2 + TMO) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL tmo_rsp_valid k=%0d got=%b", k, rsp_valid); end
            checks++; if (gen_mode !== ((k <= 1 + TMO) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL tmo_mode k=%0d got=%b", k, gen_mode); end
            if (k == 2 + TMO) begin
                checks++; if (rsp_err !== 1'b1 || rsp_pubkey !== 8'h00) begin errors++; $display("FAIL tmo_err got=%b/%h want=1/00", rsp_err, rsp_pubkey); end
            end
        end
        @(posedge clk); #1;
        stub_dead = 1'b0;
        set_req(1, 1'b1, 8'd10);
        wait_ready(4, got);
        checks++; if (got !== 4'b0010) begin errors++; $display("FAIL tmo_next_accept got=%b want=0010", got); end
        @(posedge clk); #1 set_req(1, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0010 || rsp_pubkey !== 8'd8 || rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_next_rsp got=%b/%0d/%b", rsp_valid, rsp_pubkey, rsp_err); end
    endtask

    task automatic test_skip;
        logic [N-1:0] got;
        do_reset;
        set_req(3, 1'b1, 8'd20);
        wait_ready(8, got);
        checks++; if (got !== 4'b1000) begin errors++; $display("FAIL skip_first got=%b want=1000", got); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                set_req(3, 1'b1, 8'd30);
                set_req(1, 1'b1, 8'd40);
            end
            @(negedge clk);
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL skip_busy_ready k=%0d got=%b", k, req_ready); end
        end
        @(posedge clk); #1;
        wait_ready(2, got);
        checks++; if (got !== 4'b0010) begin errors++; $display("FAIL skip_grant1 got=%b want=0010", got); end
        @(posedge clk); #1 set_req(1, 1'b0, 8'd0);
        wait_ready(8, got);
        checks++; if (got !== 4'b1000) begin errors++; $display("FAIL skip_grant3 got=%b want=1000", got); end
    endtask

    task automatic test_reset_mid_wait;
        logic [N-1:0] got;
        do_reset;
        stub_dead = 1'b1;
        set_req(1, 1'b1, 8'd50);
        wait_ready(8, got);
        checks++; if (got !== 4'b0010) begin errors++; $display("FAIL rmw_accept got=%b", got); end
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'd60);
        set_req(2, 1'b1, 8'd70);
        @(negedge clk);
        @(negedge clk);
        checks++; if (gen_mode !== 2'b01) begin errors++; $display("FAIL rmw_in_wait got=%b want=01", gen_mode); end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checks++; if (gen_mode !== 2'b00 || gen_seckey !== 8'h00) begin errors++; $display("FAIL rmw_gen_reset got=%b/%h", gen_mode, gen_seckey); end
        checks++; if (rsp_valid !== '0 || req_ready !== '0) begin errors++; $display("FAIL rmw_rsp_reset got=%b/%b", rsp_valid, req_ready); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        stub_dead = 1'b0;
        set_req(1, 1'b0, 8'd0);
        wait_ready(4, got);
        checks++; if (got !== 4'b0001) begin errors++; $display("FAIL rmw_regrant got=%b want=0001", got); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) set_req(0, 1'b0, 8'd0);
            @(negedge clk);
            checks++; if (rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL rmw_rsp k=%0d got=%b", k, rsp_valid); end
        end
        checks++; if (rsp_pubkey !== pk_of(60)) begin errors++; $display("FAIL rmw_pubkey got=%0d want=%0d", rsp_pubkey, pk_of(60)); end
    endtask

    task automatic test_random;
        int last = N - 1, pidx = 0, pacc = 0, prsp = 0, exp_g;
        bit pend = 1'b0;
        logic [7:0] pkey = 8'h00, exp_pk = 8'h00;
        logic exp_err = 1'b0;
        logic [N-1:0] acc_now = '0, exp_rdy;
        do_reset;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_now[i]) begin
                    if ($urandom_range(1, 0) == 0) set_req(i, 1'b0, 8'd0);
                    else set_req(i, 1'b1, rnd_key());
                end else if (req_valid[i]) begin
                    if ($urandom_range(19, 0) == 0) set_req(i, 1'b0, 8'd0);
                end else if ($urandom_range(9, 0) < 3) begin
                    set_req(i, 1'b1, rnd_key());
                end
            end
            acc_now = '0;
            @(negedge clk);
            if (pend && c == prsp) begin
                checks++;
                if (rsp_valid !== oh(pidx) || rsp_pubkey !== exp_pk || rsp_err !== exp_err || req_ready !== '0) begin
                    errors++; $display("FAIL rnd_rsp c=%0d got=%b/%0d/%b want=%b/%0d/%b", c, rsp_valid, rsp_pubkey, rsp_err, oh(pidx), exp_pk, exp_err);
                end
                pend = 1'b0;
                last = pidx;
            end else if (pend) begin
                checks++;
                if (rsp_valid !== '0 || req_ready !== '0 || gen_mode !== 2'b01 || gen_seckey !== pkey) begin
                    errors++; $display("FAIL rnd_busy c=%0d rsp=%b rdy=%b mode=%b key=%h want key=%h", c, rsp_valid, req_ready, gen_mode, gen_seckey, pkey);
                end
            end else begin
                exp_g   = rr_pick(req_valid, last);
                exp_rdy = (exp_g < 0) ? '0 : oh(exp_g);
                checks++;
                if (req_ready !== exp_rdy || rsp_valid !== '0) begin
                    errors++; $display("FAIL rnd_grant c=%0d got=%b want=%b rsp=%b", c, req_ready, exp_rdy, rsp_valid);
                end
                if (exp_g >= 0) begin
                    pend      = 1'b1;
                    pidx      = exp_g;
                    pacc      = c;
                    pkey      = req_seckey[8*exp_g +: 8];
                    stub_dead = ($urandom_range(6, 0) == 0);
                    acc_now   = oh(exp_g);
                    if (pkey == 8'd0 || pkey >= 8'd227) begin
                        exp_err = 1'b1; exp_pk = 8'h00; prsp = pacc + 2;
                    end else if (stub_dead) begin
                        exp_err = 1'b1; exp_pk = 8'h00; prsp = pacc + 2 + TMO;
                    end else begin
                        exp_err = 1'b0; exp_pk = pk_of(int'(pkey)); prsp = pacc + 3;
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_invalid_key;
        test_timeout;
        test_skip;
        test_reset_mid_wait;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
